// File: rtl/hstl_bidir_xfer_ctrl.sv
// rtl/hstl_bidir_xfer_ctrl.sv - half-duplex single-wire transfer engine driving a bidirectional HSTL DCI buffer
module hstl_bidir_xfer_ctrl #(
    parameter int DW  = 8,
    parameter int DIV = 4,
    parameter int TA  = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [DW-1:0] WR_DATA,
    input  logic          RD_EN,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] RD_DATA,
    output logic          PAD_I,
    output logic          PAD_T,
    input  logic          PAD_O
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = (DW  > 1) ? $clog2(DW)  : 1;
    localparam int TCW = (TA  > 1) ? $clog2(TA)  : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TURN,
        S_READ,
        S_PARK
    } state_t;

    state_t         state;
    logic [DCW-1:0] div_cnt;
    logic [BCW-1:0] bit_cnt;
    logic [TCW-1:0] ta_cnt;
    logic [DW-1:0]  wr_sh;
    logic [DW-1:0]  rd_sh;
    logic           rd_en_q;

    logic           div_last;
    logic           bit_last;
    logic           ta_last;
    logic           sample;
    logic [DW-1:0]  wr_next;
    logic [DW:0]    rd_cat;
    logic [DW-1:0]  rd_next;

    assign div_last = (div_cnt == DCW'(DIV - 1));
    assign bit_last = (bit_cnt == BCW'(DW - 1));
    assign ta_last  = (ta_cnt  == TCW'(TA - 1));
    // Mid-bit sampling keeps the read eye centred on the remote driver's bit period
    assign sample   = (div_cnt == DCW'(DIV / 2));
    assign wr_next  = wr_sh << 1;
    assign rd_cat   = {rd_sh, PAD_O};
    assign rd_next  = rd_cat[DW-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            ta_cnt  <= '0;
            wr_sh   <= '0;
            rd_sh   <= '0;
            rd_en_q <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RD_DATA <= '0;
            PAD_I   <= 1'b0;
            PAD_T   <= 1'b1;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        wr_sh   <= WR_DATA;
                        rd_en_q <= RD_EN;
                        PAD_I   <= WR_DATA[DW-1];
                        PAD_T   <= 1'b0;
                        BUSY    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            ta_cnt  <= '0;
                            PAD_T   <= 1'b1;
                            PAD_I   <= 1'b0;
                            state   <= rd_en_q ? S_TURN : S_PARK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            wr_sh   <= wr_next;
                            PAD_I   <= wr_next[DW-1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_TURN: begin
                    if (ta_last) begin
                        ta_cnt  <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        rd_sh   <= '0;
                        state   <= S_READ;
                    end else begin
                        ta_cnt <= ta_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (sample) rd_sh <= rd_next;
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            // With DIV=2 the last sample lands on the closing edge itself
                            RD_DATA <= sample ? rd_next : rd_sh;
                            state   <= S_PARK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_PARK: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hstl_bidir_xfer_ctrl.sv
// tb/tb_hstl_bidir_xfer_ctrl.sv - scoreboard bench for hstl_bidir_xfer_ctrl
module tb_hstl_bidir_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       busy, done, pad_i, pad_t;
    logic [7:0] rd_data;
    logic       pad_o = 1'b0;

    logic       s2_start = 1'b0;
    logic [3:0] s2_wr_data = 4'h9;
    logic       s2_busy, s2_done, s2_pad_i, s2_pad_t;
    logic [3:0] s2_rd_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] rd_data;
        int         latency;
    } exp_t;
    exp_t sb_q[$];
    logic [7:0] last_rd = 8'h00;

    always #5 clk = ~clk;

    hstl_bidir_xfer_ctrl u_dut (
        .CLK(clk), .RST(rst), .START(start), .WR_DATA(wr_data), .RD_EN(rd_en),
        .BUSY(busy), .DONE(done), .RD_DATA(rd_data),
        .PAD_I(pad_i), .PAD_T(pad_t), .PAD_O(pad_o)
    );

    hstl_bidir_xfer_ctrl #(.DW(4), .DIV(2), .TA(1)) u_dut2 (
        .CLK(clk), .RST(rst), .START(s2_start), .WR_DATA(s2_wr_data), .RD_EN(1'b0),
        .BUSY(s2_busy), .DONE(s2_done), .RD_DATA(s2_rd_data),
        .PAD_I(s2_pad_i), .PAD_T(s2_pad_t), .PAD_O(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; runs one transaction cycle by cycle from the START edge.
    task automatic run_xact(input logic [7:0] wd, input logic rd, input logic [7:0] rx,
                            input int busy_start_at, input int rst_at);
        exp_t e;
        int   done_c;
        int   seen;
        exp_t got;
        done_c = rd ? 67 : 33;
        e.rd_data = rd ? rx : last_rd;
        e.latency = done_c;
        sb_q.push_back(e);
        wr_data = wd;
        rd_en   = rd;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c <= done_c + 2; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_pad_t", pad_t, 1'b1);
                check("rst_busy", busy, 1'b0);
                check("rst_rd_data", rd_data, 8'h00);
                sb_q.delete();
                last_rd = 8'h00;
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 80; i++) begin
                    if (done !== 1'b0) check("rst_no_done", done, 1'b0);
                    if (pad_t !== 1'b1) check("rst_idle_pad_t", pad_t, 1'b1);
                    @(negedge clk);
                end
                check("rst_final_rd_data", rd_data, 8'h00);
                check("rst_final_busy", busy, 1'b0);
                return;
            end
            check("pad_t", pad_t, (c < 32) ? 1'b0 : 1'b1);
            if (c < 32) check("pad_i", pad_i, wd[7 - c / 4]);
            else        check("pad_i_rel", pad_i, 1'b0);
            check("busy", busy, (c < done_c) ? 1'b1 : 1'b0);
            if (done === 1'b1) begin
                seen++;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    got = sb_q.pop_front();
                    check("rd_data", rd_data, got.rd_data);
                    check("latency", c, got.latency);
                    last_rd = got.rd_data;
                end
            end
            pad_o = (rd && c >= 34 && c < 66) ? rx[7 - (c - 34) / 4] : 1'b0;
            if (c == busy_start_at) begin
                start   = 1'b1;
                wr_data = 8'hFF;
                rd_en   = 1'b1;
            end else if (c == busy_start_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("done_count", seen, 1);
        pad_o = 1'b0;
    endtask

    initial begin
        int done_cyc[$];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("idle_pad_t", pad_t, 1'b1);
            check("idle_pad_i", pad_i, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_rd_data", rd_data, 8'h00);
            @(negedge clk);
        end

        run_xact(8'hA5, 1'b0, 8'h00, -10, -1);
        run_xact(8'h3C, 1'b1, 8'hC3, -10, -1);
        check("rd_hold_c3", rd_data, 8'hC3);
        run_xact(8'hA5, 1'b0, 8'h00, 10, -1);
        check("wo_keeps_rd", rd_data, 8'hC3);
        run_xact(8'h5A, 1'b1, 8'h96, -10, 40);
        check("sb_drained", sb_q.size(), 0);

        s2_start = 1'b1;
        for (int c = 0; c < 60 && done_cyc.size() < 3; c++) begin
            @(negedge clk);
            if (s2_done === 1'b1) done_cyc.push_back(c);
            else if (done_cyc.size() > 0 && done_cyc[done_cyc.size() - 1] == c - 1)
                check("b2b_pad_t_after_done", s2_pad_t, 1'b0);
        end
        check("b2b_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_period1", done_cyc[1] - done_cyc[0], 10);
            check("b2b_period2", done_cyc[2] - done_cyc[1], 10);
        end
        s2_start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hstl_bidir_xfer_ctrl.md
Name: hstl_bidir_xfer_ctrl

Overview:
- Half-duplex, single-wire serial transfer engine that sits directly upstream of a bidirectional HSTL DCI I/O buffer.
- Drives the buffer's data input (PAD_I) and tristate control (PAD_T; 1 = high-Z, 0 = drive) and samples the buffer's receive output (PAD_O).
- Each transaction shifts out one write word MSB-first, optionally releases the line for a turnaround gap, then shifts in one read word MSB-first.

Parameters:
DW, 8, word width in bits (>=1)
DIV, 4, clocks per bit period (>=2)
TA, 2, turnaround length in clocks between write and read phases (>=1)

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  request a transaction; sampled only in IDLE
WR_DATA  input  DW  word to transmit; captured on accepted START
RD_EN  input  1  1 = perform read phase after write; captured on accepted START
BUSY  output  1  high while a transaction is in progress
DONE  output  1  one-clock pulse at transaction completion
RD_DATA  output  DW  last received word; updated only at the end of a read phase
PAD_I  output  1  serial data to the I/O buffer
PAD_T  output  1  tristate control to the I/O buffer; 1 = release line
PAD_O  input  1  received line value from the I/O buffer

Behaviour:
- Reset (async, immediate, including mid-transaction): state=IDLE, PAD_T=1, PAD_I=0, BUSY=0, DONE=0, RD_DATA=0, all counters and shift registers 0.
- States: IDLE, WRITE, TURN, READ, PARK. All outputs are registered.
- IDLE:
  - On an edge with START=1, capture WR_DATA and RD_EN; state<=WRITE, PAD_T<=0, PAD_I<=WR_DATA[DW-1], BUSY<=1.
  - START=0 holds IDLE with PAD_T=1.
- WRITE:
  - Each bit is held for exactly DIV clocks, MSB first. A div counter runs 0..DIV-1; a bit counter runs 0..DW-1.
  - At the end of the last bit: if RD_EN was captured, state<=TURN and PAD_T<=1, PAD_I<=0; otherwise state<=PARK with the same PAD_T/PAD_I values.
- TURN: line released for exactly TA clocks, then state<=READ.
- READ:
  - PAD_T stays 1. DW bit periods of DIV clocks each.
  - PAD_O is sampled into the shift register on the edge where div counter == DIV/2 (integer division), MSB first.
  - At the end of the last bit, RD_DATA<=shift register and state<=PARK.
- PARK:
  - Exactly one clock with PAD_T=1.
  - Next edge: state<=IDLE, BUSY<=0, DONE<=1 for that single cycle.
- Latency (START accepted at edge k):
  - Write-only: DONE high in the cycle after edge k+DW*DIV+1.
  - With read: DONE high in the cycle after edge k+DW*DIV+TA+DW*DIV+1.
  - Defaults: 33 clocks write-only, 67 clocks with read.
- PAD_T=0 only in WRITE. Line is never driven in TURN, READ, PARK or IDLE.
- START while BUSY=1 is ignored: no queuing, and WR_DATA/RD_EN changes have no effect.
- START asserted in the same cycle DONE pulses (state IDLE) is accepted; back-to-back transactions have exactly one IDLE cycle between them.
- Write-only transaction leaves RD_DATA unchanged.
- Reset asserted mid-READ: RD_DATA returns to 0; the partial word is discarded.
- Bit/div counters wrap only via explicit end-of-phase conditions, never by natural overflow.

Test Plan:
- Reset then idle: RST pulse, START=0 for 20 clocks -> PAD_T=1, PAD_I=0, BUSY=0, DONE=0, RD_DATA=0 throughout.
- Write-only: WR_DATA=8'hA5, RD_EN=0, START one clock (defaults) -> PAD_T=0 for 32 clocks; PAD_I = 1,0,1,0,0,1,0,1, each held 4 clocks; DONE pulse 33 clocks after START edge; RD_DATA stays 0.
- Write+read: WR_DATA=8'h3C, RD_EN=1; bench drives 8'hC3 MSB-first on PAD_O only while PAD_T=1 during READ, with a 4-clock bit period aligned to the controller -> PAD_T rises right after the last write bit and stays high for TA=2 plus 32 clocks; RD_DATA=8'hC3 with DONE at 67 clocks.
- START while busy: second START with WR_DATA=8'hFF at clock 10 of the write from scenario 2 -> ignored; PAD_I pattern still matches 8'hA5; exactly one DONE pulse.
- Reset mid-operation: assert RST at clock 40 of a write+read transaction -> PAD_T=1 and BUSY=0 in the same cycle; no DONE pulse; RD_DATA=0.
- Back-to-back with non-default parameters: DW=4, DIV=2, TA=1; START held high continuously -> transactions repeat with one IDLE cycle between DONE and the next PAD_T=0.
